alu_sequencer: RTL and testbench

Control-side counterpart of the 4-bit ALU. It accepts 8-bit instructions over a valid/ready handshake, decodes each one into the ALU's one-hot control strobes, and drives the ALU operands from an internal 4-bit accumulator and the instruction immediate. It then writes the ALU result and flags back into the accumulator and flag registers. It sits between instruction fetch and the ALU; the ALU stays purely datapath.

---
 rtl/alu_sequencer_pkg.sv | 33 +++
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/alu_sequencer_strobe_decode.sv | 23 ++
 rtl/alu_sequencer.sv | 81 ++++++++
 tb/tb_alu_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: opcodes, FSM states and strobe indices shared by the sequencer
package alu_sequencer_pkg;
  localparam int DATA_W = 4;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_INV = 4'h6;
  localparam logic [3:0] OP_CLR = 4'h7;
  localparam logic [3:0] OP_LSH = 4'h8;
  localparam logic [3:0] OP_RSH = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam int S_ADD = 0;
  localparam int S_SUB = 1;
  localparam int S_LSR = 2;
  localparam int S_LSH = 3;
  localparam int S_RSH = 4;
  localparam int S_AND = 5;
  localparam int S_OR  = 6;
  localparam int S_XOR = 7;
  localparam int S_INV = 8;
  localparam int S_CLR = 9;
  typedef logic [9:0] strobe_t;
  typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_SHL, ST_SHX, ST_RET} state_t;
  function automatic logic is_alu_op(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_CLR;
  endfunction
  function automatic logic is_shift(input logic [3:0] op);
    return op == OP_LSH || op == OP_RSH;
  endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake, ALU control/operand bus and architectural state
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W+3:0] instr;
  logic              alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh;
  logic              alu_and, alu_or, alu_xor, alu_inv, alu_clr;
  logic [DATA_W-1:0] alu_in1, alu_in2, alu_out;
  logic              alu_overflow, alu_shift_flag;
  logic [DATA_W-1:0] acc;
  logic              carry_flag, zero_flag, done, illegal, busy;
  modport master (
    output instr_valid, instr, alu_out, alu_overflow, alu_shift_flag,
    input  instr_ready, alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh, alu_and, alu_or,
           alu_xor, alu_inv, alu_clr, alu_in1, alu_in2, acc, carry_flag, zero_flag,
           done, illegal, busy
  );
  modport slave (
    input  instr_valid, instr, alu_out, alu_overflow, alu_shift_flag,
    output instr_ready, alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh, alu_and, alu_or,
           alu_xor, alu_inv, alu_clr, alu_in1, alu_in2, acc, carry_flag, zero_flag,
           done, illegal, busy
  );
endinterface

// File: rtl/alu_sequencer_strobe_decode.sv
// alu_strobe_decode: maps registered (state, opcode) to the ten one-hot ALU strobes
module alu_strobe_decode
  import alu_sequencer_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  output strobe_t    strb
);
  // every strobe is a pure AND of registered terms, so at most one can be high
  always_comb begin
    strb        = '0;
    strb[S_ADD] = state == ST_EXEC && op == OP_ADD;
    strb[S_SUB] = state == ST_EXEC && op == OP_SUB;
    strb[S_AND] = state == ST_EXEC && op == OP_AND;
    strb[S_OR]  = state == ST_EXEC && op == OP_OR;
    strb[S_XOR] = state == ST_EXEC && op == OP_XOR;
    strb[S_INV] = state == ST_EXEC && op == OP_INV;
    strb[S_CLR] = state == ST_EXEC && op == OP_CLR;
    strb[S_LSR] = state == ST_SHL;
    strb[S_LSH] = state == ST_SHX && op == OP_LSH;
    strb[S_RSH] = state == ST_SHX && op == OP_RSH;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes instructions into ALU strobes and writes results back to acc/flags
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic [DATA_W-1:0] ACC_RST = '0
) (
  input logic clk,
  input logic reset,
  alu_sequencer_if.slave bus
);
  state_t            state;
  logic [3:0]        op;
  logic [DATA_W-1:0] imm, acc;
  logic              carry, zero, done, illegal;
  strobe_t           strb;
  alu_strobe_decode u_dec (.state(state), .op(op), .strb(strb));
  // instruction FSM with accumulator and flag writeback; done/illegal are registered into RET
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      op      <= OP_NOP;
      imm     <= '0;
      acc     <= ACC_RST;
      carry   <= 1'b0;
      zero    <= 1'b1;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: if (bus.instr_valid) begin
          op    <= bus.instr[DATA_W+3:DATA_W];
          imm   <= bus.instr[DATA_W-1:0];
          state <= is_shift(bus.instr[DATA_W+3:DATA_W]) ? ST_SHL : ST_EXEC;
        end
        ST_EXEC: begin
          if (is_alu_op(op)) begin
            acc   <= bus.alu_out;
            carry <= bus.alu_overflow;
            zero  <= bus.alu_out == '0;
          end else if (op == OP_LDI) begin
            acc  <= imm;
            zero <= imm == '0;
          end
          done    <= 1'b1;
          illegal <= op > OP_LDI;
          state   <= ST_RET;
        end
        ST_SHL: state <= ST_SHX;
        ST_SHX: begin
          acc   <= bus.alu_out;
          carry <= bus.alu_shift_flag;
          zero  <= bus.alu_out == '0;
          done  <= 1'b1;
          state <= ST_RET;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign bus.instr_ready = state == ST_IDLE;
  assign bus.busy        = state != ST_IDLE;
  assign bus.alu_in1     = acc;
  assign bus.alu_in2     = imm;
  assign bus.acc         = acc;
  assign bus.carry_flag  = carry;
  assign bus.zero_flag   = zero;
  assign bus.done        = done;
  assign bus.illegal     = illegal;
  assign bus.alu_add     = strb[S_ADD];
  assign bus.alu_sub     = strb[S_SUB];
  assign bus.alu_lsr     = strb[S_LSR];
  assign bus.alu_lsh     = strb[S_LSH];
  assign bus.alu_rsh     = strb[S_RSH];
  assign bus.alu_and     = strb[S_AND];
  assign bus.alu_or      = strb[S_OR];
  assign bus.alu_xor     = strb[S_XOR];
  assign bus.alu_inv     = strb[S_INV];
  assign bus.alu_clr     = strb[S_CLR];
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed instructions checked by a scoreboard against an arithmetic model
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  alu_sequencer_if bus();
  alu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [3:0] op;
    logic [3:0] acc;
    logic       c;
    logic       z;
    logic       ill;
    int         acc_p;
    int         lat;
  } exp_t;
  exp_t q[$];
  int pcyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] m_acc = 4'h0;
  logic       m_c = 1'b0;
  logic [3:0] sreg;
  logic [4:0] t;
  logic [9:0] sv;
  assign sv = {bus.alu_add, bus.alu_sub, bus.alu_lsr, bus.alu_lsh, bus.alu_rsh,
               bus.alu_and, bus.alu_or, bus.alu_xor, bus.alu_inv, bus.alu_clr};
  always @(posedge clk) pcyc <= pcyc + 1;
  // stand-in ALU: its shift register loads in1 on the lsr edge
  always @(posedge clk) if (bus.alu_lsr) sreg <= bus.alu_in1;
  always_comb begin
    t = 5'd0;
    bus.alu_shift_flag = 1'b0;
    if (bus.alu_add) t = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
    else if (bus.alu_sub) t = {1'b0, bus.alu_in1} - {1'b0, bus.alu_in2};
    else if (bus.alu_and) t = {1'b0, bus.alu_in1 & bus.alu_in2};
    else if (bus.alu_or)  t = {1'b0, bus.alu_in1 | bus.alu_in2};
    else if (bus.alu_xor) t = {1'b0, bus.alu_in1 ^ bus.alu_in2};
    else if (bus.alu_inv) t = {1'b0, ~bus.alu_in1};
    else if (bus.alu_lsh) begin t = {1'b0, sreg[2:0], 1'b0}; bus.alu_shift_flag = sreg[3]; end
    else if (bus.alu_rsh) begin t = {2'b0, sreg[3:1]}; bus.alu_shift_flag = sreg[0]; end
    bus.alu_out = t[3:0];
    bus.alu_overflow = (bus.alu_add | bus.alu_sub) & t[4];
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask
  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask
  // strobe order {add,sub,lsr,lsh,rsh,and,or,xor,inv,clr}; off counts cycles after the accept edge
  function automatic logic [9:0] exp_strb(input logic [3:0] op, input int off);
    logic [9:0] v = '0;
    if (op == 4'h8 || op == 4'h9) begin
      if (off == 1) v[7] = 1'b1;
      else if (off == 2) v[op == 4'h8 ? 6 : 5] = 1'b1;
    end else if (off == 1) begin
      case (op)
        4'h1: v[9] = 1'b1;
        4'h2: v[8] = 1'b1;
        4'h3: v[4] = 1'b1;
        4'h4: v[3] = 1'b1;
        4'h5: v[2] = 1'b1;
        4'h6: v[1] = 1'b1;
        4'h7: v[0] = 1'b1;
        default: ;
      endcase
    end
    return v;
  endfunction
  task automatic issue(input logic [3:0] op, input logic [3:0] imm);
    int n = 0;
    int a, b;
    exp_t e;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = {op, imm};
    while (!bus.instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) begin
      fail_now("accept_timeout");
      bus.instr_valid = 1'b0;
      return;
    end
    a = int'(m_acc);
    b = int'(imm);
    case (op)
      4'h1: begin m_c = (a + b) > 15; m_acc = 4'((a + b) % 16); end
      4'h2: begin m_c = b > a; m_acc = 4'((a - b + 16) % 16); end
      4'h3: begin m_c = 1'b0; m_acc = 4'(a & b); end
      4'h4: begin m_c = 1'b0; m_acc = 4'(a | b); end
      4'h5: begin m_c = 1'b0; m_acc = 4'(a ^ b); end
      4'h6: begin m_c = 1'b0; m_acc = 4'(15 - a); end
      4'h7: begin m_c = 1'b0; m_acc = 4'h0; end
      4'h8: begin m_c = a >= 8; m_acc = 4'((a * 2) % 16); end
      4'h9: begin m_c = (a % 2) == 1; m_acc = 4'(a / 2); end
      4'hA: m_acc = imm;
      default: ;
    endcase
    e = '{op, m_acc, m_c, m_acc == 4'h0, op > 4'hA, pcyc + 1, (op == 4'h8 || op == 4'h9) ? 3 : 2};
    q.push_back(e);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail_now("retire_timeout");
      q.delete();
    end
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_acc"}, bus.acc, 4'h0);
    check({tag, "_carry"}, bus.carry_flag, 1'b0);
    check({tag, "_zero"}, bus.zero_flag, 1'b1);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_illegal"}, bus.illegal, 1'b0);
    check({tag, "_in2"}, bus.alu_in2, 4'h0);
    check({tag, "_strobes"}, sv, 10'h0);
    check({tag, "_ready"}, bus.instr_ready, 1'b1);
  endtask
  // monitor: per-cycle strobe check and scoreboard pop on every retirement
  initial forever begin
    exp_t e;
    logic [9:0] ev;
    @(negedge clk);
    ev = q.size() != 0 ? exp_strb(q[0].op, pcyc - q[0].acc_p + 1) : 10'h0;
    check("strobes", sv, ev);
    check("busy", bus.busy, !bus.instr_ready);
    if (bus.done) begin
      if (q.size() == 0) fail_now("spurious_done");
      else begin
        e = q.pop_front();
        check("latency", pcyc - e.acc_p + 1, e.lat);
        check("acc", bus.acc, e.acc);
        check("carry", bus.carry_flag, e.c);
        check("zero", bus.zero_flag, e.z);
        check("illegal", bus.illegal, e.ill);
      end
    end else check("illegal_without_done", bus.illegal, 1'b0);
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    repeat (2) @(negedge clk);
    reset_checks("rst");
    #2 reset = 1'b1;
    @(negedge clk);
    reset_checks("post_rst");
    issue(4'hA, 4'h5); issue(4'h1, 4'h3); wait_idle();
    issue(4'hA, 4'hF); issue(4'h1, 4'h2); issue(4'h3, 4'h0); wait_idle();
    issue(4'hA, 4'h3); issue(4'h2, 4'h5); wait_idle();
    issue(4'hA, 4'h9); issue(4'h8, 4'h0); issue(4'h9, 4'h0); wait_idle();
    issue(4'hC, 4'h3); issue(4'h1, 4'h2); wait_idle();
    issue(4'hA, 4'h9); wait_idle();
    issue(4'h8, 4'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 reset_checks("mid_shx");
    q.delete();
    m_acc = 4'h0;
    m_c = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    issue(4'h1, 4'h4); wait_idle();
    repeat (150) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
